// File: rtl/pc_fetch_unit_pkg.sv
// Shared IF-stage definitions: fetch FSM states, reset/NOP words, PC step
// and the IF/ID pipeline register layout.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    KILL  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  // Sequential PC successor; wraps modulo 2^32
  function automatic logic [31:0] pc_plus_step(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  // Branch/jump targets are word addresses; low two bits are dropped
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Flush forces a NOP bubble and beats stall;
// stall holds the current entry; otherwise the offered entry is loaded.
module if_id_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   stall,
  input  if_id_t next_entry,
  output if_id_t entry
);

  // Register update with priority flush > stall > load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '{instr: NOP, pc_plus4: 32'd0, pc: 32'd0, valid: 1'b0};
    end else if (flush) begin
      entry <= '{instr: NOP, pc_plus4: 32'd0, pc: 32'd0, valid: 1'b0};
    end else if (!stall) begin
      entry <= next_entry;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage: owns the PC, drives the req/ack instruction-memory port and
// fills IF/ID. Redirects from ID flush IF/ID; a fetch already in flight on
// the wrong path is waited out in KILL and its data thrown away.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic [31:0] PCD,
  output logic        ValidD
);

  fetch_state_t state;
  logic [31:0]  pc_f;
  logic [31:0]  redir_pend;
  logic [31:0]  fetch_buf;
  logic         buf_valid;
  logic         req_q;
  logic         ack_hit;
  logic         deliver_mem;
  logic         deliver_buf;
  if_id_t       next_entry;
  if_id_t       entry;

  assign imem_req  = req_q;
  assign imem_addr = pc_f;
  assign ack_hit   = req_q & imem_ack;

  assign deliver_mem = (state == FETCH) & ack_hit   & ~StallD & ~redirect_valid;
  assign deliver_buf = (state == HOLD)  & buf_valid & ~StallD & ~redirect_valid;

  // Select what IF/ID receives this cycle: fresh word, buffered word or a bubble
  always_comb begin
    next_entry = '{instr: NOP, pc_plus4: 32'd0, pc: 32'd0, valid: 1'b0};
    if (deliver_mem) begin
      next_entry = '{instr: imem_rdata, pc_plus4: pc_plus_step(pc_f), pc: pc_f, valid: 1'b1};
    end else if (deliver_buf) begin
      next_entry = '{instr: fetch_buf, pc_plus4: pc_plus_step(pc_f), pc: pc_f, valid: 1'b1};
    end
  end

  // Fetch FSM with PC, request, one-entry buffer and pending-redirect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc_f       <= RESET_PC;
      req_q      <= 1'b0;
      redir_pend <= 32'd0;
      fetch_buf  <= NOP;
      buf_valid  <= 1'b0;
    end else if (redirect_valid) begin
      buf_valid <= 1'b0;
      if (req_q && !imem_ack) begin
        redir_pend <= align_word(redirect_target);
        state      <= KILL;
      end else begin
        pc_f  <= align_word(redirect_target);
        state <= FETCH;
        req_q <= !StallF;
      end
    end else begin
      case (state)
        FETCH: begin
          if (ack_hit) begin
            if (StallD) begin
              fetch_buf <= imem_rdata;
              buf_valid <= 1'b1;
              state     <= HOLD;
              req_q     <= 1'b0;
            end else begin
              pc_f  <= pc_plus_step(pc_f);
              req_q <= !StallF;
            end
          end else if (!req_q) begin
            req_q <= !StallF;
          end
        end
        HOLD: begin
          if (!StallD) begin
            buf_valid <= 1'b0;
            pc_f      <= pc_plus_step(pc_f);
            state     <= FETCH;
            req_q     <= !StallF;
          end
        end
        KILL: begin
          if (ack_hit) begin
            pc_f  <= redir_pend;
            state <= FETCH;
            req_q <= !StallF;
          end
        end
        default: begin
          state <= FETCH;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(.NOP(NOP)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .stall      (StallD),
    .next_entry (next_entry),
    .entry      (entry)
  );

  assign InstrD   = entry.instr;
  assign PCPlus4D = entry.pc_plus4;
  assign PCD      = entry.pc;
  assign ValidD   = entry.valid;

endmodule
